// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int WORD_W = 16;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/dmem_array.sv
// Synchronous 2**ADDR_W x WORD_W storage with one write port and one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on a read, so it holds its last value; same-address write bypasses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage: stalls LATENCY cycles per request.
// Optional DMEM_WR_BUFFER_EN adds a single-entry posted write buffer.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [15:0]       wrt_data,
  input  logic              hlt,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic              stall
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_data;
  op_t               lat_op;

  logic              rd_req, wr_req, fsm_req;
  logic              start, access;
  op_t               acc_op;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_data;
  logic              fsm_stall, wb_stall;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;

  // Write wins when both are requested; the read is dropped.
  assign wr_req = we & ~hlt;
  assign rd_req = re & ~we & ~hlt;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    access    = 1'b0;
    acc_op    = lat_op;
    acc_addr  = lat_addr;
    acc_data  = lat_data;
    case (state)
      IDLE: begin
        if (fsm_req) begin
          start    = 1'b1;
          acc_op   = wr_req ? OP_WR : OP_RD;
          acc_addr = addr[ADDR_W-1:0];
          acc_data = wrt_data;
          if (LATENCY == 1) access = 1'b1;
          else state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          access    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_stall = start | (state == BUSY);
  assign arr_re    = access & (acc_op == OP_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_op   <= OP_RD;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= arr_re;
      if (start) begin
        cnt      <= CNT_LOAD;
        lat_addr <= acc_addr;
        lat_data <= acc_data;
        lat_op   <= acc_op;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef DMEM_WR_BUFFER_EN
  logic              buf_valid;
  logic [3:0]        buf_cnt;
  logic [ADDR_W-1:0] buf_addr;
  logic [WORD_W-1:0] buf_data;
  logic              drain, wr_try, capture;
  logic              fwd_sel;
  logic [WORD_W-1:0] fwd_data;
  logic              unused_ok;

  // Only reads go through the FSM; writes are posted into the buffer.
  assign fsm_req  = rd_req;
  assign drain    = buf_valid & (buf_cnt <= 4'd1);
  assign wr_try   = (state == IDLE) & wr_req;
  assign capture  = wr_try & (~buf_valid | drain);
  assign wb_stall = wr_try & ~capture;

  assign arr_we    = drain;
  assign arr_waddr = buf_addr;
  assign arr_wdata = buf_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_cnt   <= '0;
      buf_addr  <= '0;
      buf_data  <= '0;
      fwd_sel   <= 1'b0;
      fwd_data  <= '0;
    end else begin
      if (capture) begin
        buf_valid <= 1'b1;
        buf_cnt   <= CNT_LOAD;
        buf_addr  <= addr[ADDR_W-1:0];
        buf_data  <= wrt_data;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end else if (buf_valid) begin
        buf_cnt <= buf_cnt - 4'd1;
      end
      if (arr_re) begin
        fwd_sel  <= buf_valid & (buf_addr == acc_addr);
        fwd_data <= buf_data;
      end
    end
  end

  assign rd_data   = fwd_sel ? fwd_data : arr_rdata;
  assign unused_ok = ^{addr[15:ADDR_W], acc_data};
`else
  logic unused_ok;

  assign fsm_req   = rd_req | wr_req;
  assign wb_stall  = 1'b0;
  assign arr_we    = access & (acc_op == OP_WR);
  assign arr_waddr = acc_addr;
  assign arr_wdata = acc_data;
  assign rd_data   = arr_rdata;
  assign unused_ok = ^addr[15:ADDR_W];
`endif

  // Reset is asynchronous, so the combinational request path must be masked too.
  assign stall = ~rst & (fsm_stall | wb_stall);

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (acc_addr),
    .rdata (arr_rdata)
  );

endmodule
